adc_fe_arbiter: RTL and testbench

Shares the single ADC analog front end (power-down, one-hot channel select, 10-bit data with valid strobe) between two conversion requesters: requester 0 is the periodic sampling FSM, requester 1 is the software one-shot/debug path. It powers the front end up on demand and waits the programmed power-up time. Each conversion is granted round-robin. The block steers the channel select, returns the sampled value to the winner, and powers the front end down after an idle period. It sits between the requesters and the AST ADC pins in the always-on domain.

---
 rtl/adc_fe_arbiter.sv | 171 +++++++++++++++++
 tb/tb_adc_fe_arbiter.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/adc_fe_arbiter.sv
// Arbiter sharing the ADC analog front end between the periodic sampler (req 0)
// and the software one-shot path (req 1): power sequencing, round-robin grant, timeout.
module adc_fe_arbiter #(
  parameter int DataW      = 10,
  parameter int IdleCycles = 16
) (
  input  logic             clk_aon_i,
  input  logic             rst_aon_i,
  input  logic [3:0]       cfg_pwrup_time_i,
  input  logic [7:0]       cfg_timeout_i,
  input  logic [1:0]       req_i,
  input  logic [1:0]       req_chn_i,
  output logic [1:0]       gnt_o,
  output logic [1:0]       rsp_valid_o,
  output logic [DataW-1:0] rsp_data_o,
  output logic             rsp_err_o,
  output logic             adc_pd_o,
  output logic [1:0]       adc_chn_sel_o,
  input  logic [DataW-1:0] adc_d_i,
  input  logic             adc_d_val_i
);

  typedef enum logic [1:0] {
    ST_PWRDN = 2'd0,
    ST_PWRUP = 2'd1,
    ST_ARB   = 2'd2,
    ST_CONV  = 2'd3
  } state_e;

  localparam logic [7:0] IdleLast = 8'(IdleCycles - 1);

  state_e           r_state, w_state_next;
  logic [7:0]       r_cnt, w_cnt_next;
  logic [7:0]       r_idle_cnt, w_idle_cnt_next;
  logic             r_last_gnt, w_last_gnt_next;
  logic             r_win, w_win_next;
  logic             r_chn, w_chn_next;
  logic [1:0]       r_gnt, w_gnt_next;
  logic [1:0]       r_rsp_valid, w_rsp_valid_next;
  logic [DataW-1:0] r_rsp_data, w_rsp_data_next;
  logic             r_rsp_err, w_rsp_err_next;
  logic             r_adc_pd, w_adc_pd_next;
  logic [1:0]       r_chn_sel, w_chn_sel_next;

  logic             w_any_req;
  logic             w_pick;
  logic             w_tmo_hit;
  logic [1:0]       w_win_onehot;
  logic [1:0]       w_chn_onehot;

  assign w_any_req = |req_i;
  // On a tie the requester that did not win the last tie goes first.
  assign w_pick    = (&req_i) ? ~r_last_gnt : req_i[1];
  assign w_tmo_hit = (cfg_timeout_i != 8'd0) && (r_cnt == (cfg_timeout_i - 8'd1));

  for (genvar gi = 0; gi < 2; gi++) begin : g_onehot
    assign w_win_onehot[gi] = (r_win == 1'(gi));
    assign w_chn_onehot[gi] = (w_chn_next == 1'(gi));
  end

  always_comb begin
    w_state_next     = r_state;
    w_cnt_next       = r_cnt;
    w_idle_cnt_next  = 8'd0;
    w_last_gnt_next  = r_last_gnt;
    w_win_next       = r_win;
    w_chn_next       = r_chn;
    w_gnt_next       = 2'b00;
    w_rsp_valid_next = 2'b00;
    w_rsp_data_next  = r_rsp_data;
    w_rsp_err_next   = 1'b0;

    case (r_state)
      ST_PWRDN: begin
        w_cnt_next = 8'd0;
        if (w_any_req) begin
          w_state_next = ST_PWRUP;
        end
      end

      ST_PWRUP: begin
        if (r_cnt == {4'd0, cfg_pwrup_time_i}) begin
          w_state_next = ST_ARB;
          w_cnt_next   = 8'd0;
        end else begin
          w_cnt_next = r_cnt + 8'd1;
        end
      end

      ST_ARB: begin
        if (w_any_req) begin
          w_state_next = ST_CONV;
          w_cnt_next   = 8'd0;
          w_win_next   = w_pick;
          w_chn_next   = req_chn_i[w_pick];
          w_gnt_next   = {w_pick, ~w_pick};
          if (&req_i) begin
            w_last_gnt_next = w_pick;
          end
        end else if (r_idle_cnt == IdleLast) begin
          w_state_next = ST_PWRDN;
        end else begin
          w_idle_cnt_next = r_idle_cnt + 8'd1;
        end
      end

      ST_CONV: begin
        // Valid data takes priority over a timeout landing in the same cycle.
        if (adc_d_val_i) begin
          w_state_next     = ST_ARB;
          w_cnt_next       = 8'd0;
          w_rsp_valid_next = w_win_onehot;
          w_rsp_data_next  = adc_d_i;
        end else if (w_tmo_hit) begin
          w_state_next     = ST_ARB;
          w_cnt_next       = 8'd0;
          w_rsp_valid_next = w_win_onehot;
          w_rsp_data_next  = '0;
          w_rsp_err_next   = 1'b1;
        end else begin
          w_cnt_next = r_cnt + 8'd1;
        end
      end

      default: begin
        w_state_next = ST_PWRDN;
      end
    endcase

    w_adc_pd_next  = (w_state_next == ST_PWRDN);
    w_chn_sel_next = (w_state_next == ST_CONV) ? w_chn_onehot : 2'b00;
  end

  always_ff @(posedge clk_aon_i) begin
    if (rst_aon_i) begin
      r_state     <= ST_PWRDN;
      r_cnt       <= 8'd0;
      r_idle_cnt  <= 8'd0;
      r_last_gnt  <= 1'b1;
      r_win       <= 1'b0;
      r_chn       <= 1'b0;
      r_gnt       <= 2'b00;
      r_rsp_valid <= 2'b00;
      r_rsp_data  <= '0;
      r_rsp_err   <= 1'b0;
      r_adc_pd    <= 1'b1;
      r_chn_sel   <= 2'b00;
    end else begin
      r_state     <= w_state_next;
      r_cnt       <= w_cnt_next;
      r_idle_cnt  <= w_idle_cnt_next;
      r_last_gnt  <= w_last_gnt_next;
      r_win       <= w_win_next;
      r_chn       <= w_chn_next;
      r_gnt       <= w_gnt_next;
      r_rsp_valid <= w_rsp_valid_next;
      r_rsp_data  <= w_rsp_data_next;
      r_rsp_err   <= w_rsp_err_next;
      r_adc_pd    <= w_adc_pd_next;
      r_chn_sel   <= w_chn_sel_next;
    end
  end

  assign gnt_o         = r_gnt;
  assign rsp_valid_o   = r_rsp_valid;
  assign rsp_data_o    = r_rsp_data;
  assign rsp_err_o     = r_rsp_err;
  assign adc_pd_o      = r_adc_pd;
  assign adc_chn_sel_o = r_chn_sel;

endmodule

// File: tb/tb_adc_fe_arbiter.sv
// Scoreboard bench for adc_fe_arbiter: the stimulus queues expected grants and
// responses with their cycle numbers, and a negedge monitor checks each one as it appears.
module tb_adc_fe_arbiter;
  localparam int DW   = 10;
  localparam int IDLE = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [3:0]    cfg_pwrup_time;
  logic [7:0]    cfg_timeout;
  logic [1:0]    req;
  logic [1:0]    req_chn;
  logic [1:0]    gnt_o;
  logic [1:0]    rsp_valid_o;
  logic [DW-1:0] rsp_data_o;
  logic          rsp_err_o;
  logic          adc_pd_o;
  logic [1:0]    adc_chn_sel_o;
  logic [DW-1:0] adc_d;
  logic          adc_d_val;

  adc_fe_arbiter #(.DataW(DW), .IdleCycles(IDLE)) dut (
    .clk_aon_i        (clk),
    .rst_aon_i        (rst),
    .cfg_pwrup_time_i (cfg_pwrup_time),
    .cfg_timeout_i    (cfg_timeout),
    .req_i            (req),
    .req_chn_i        (req_chn),
    .gnt_o            (gnt_o),
    .rsp_valid_o      (rsp_valid_o),
    .rsp_data_o       (rsp_data_o),
    .rsp_err_o        (rsp_err_o),
    .adc_pd_o         (adc_pd_o),
    .adc_chn_sel_o    (adc_chn_sel_o),
    .adc_d_i          (adc_d),
    .adc_d_val_i      (adc_d_val)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit            is_rsp;
    int            at;
    logic [1:0]    vec;
    logic [1:0]    sel;
    logic [DW-1:0] data;
    logic          err;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  bit   mon_en = 1'b0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_to(input int n);
    while (cyc < n) tick();
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, want);
    end
  endtask

  task automatic push(input bit is_rsp, input int at, input logic [1:0] vec,
                      input logic [1:0] sel, input logic [DW-1:0] data, input logic err);
    exp_t e;
    e.is_rsp = is_rsp; e.at = at; e.vec = vec; e.sel = sel; e.data = data; e.err = err;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin : mon
    exp_t e;
    bit   ok;
    if (mon_en && (gnt_o !== 2'b00 || rsp_valid_o !== 2'b00)) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_output cyc=%0d gnt=%b rsp=%b data=%0h err=%b",
                 cyc, gnt_o, rsp_valid_o, rsp_data_o, rsp_err_o);
      end else begin
        e = sb.pop_front();
        if (e.is_rsp)
          ok = (rsp_valid_o === e.vec) && (gnt_o === 2'b00) && (rsp_data_o === e.data) &&
               (rsp_err_o === e.err) && (adc_chn_sel_o === 2'b00) && (cyc == e.at);
        else
          ok = (gnt_o === e.vec) && (rsp_valid_o === 2'b00) &&
               (adc_chn_sel_o === e.sel) && (adc_pd_o === 1'b0) && (cyc == e.at);
        if (ok)
          $display("ok %s cyc=%0d vec=%b sel=%b data=%0h err=%b", e.is_rsp ? "rsp" : "gnt",
                   cyc, e.is_rsp ? rsp_valid_o : gnt_o, adc_chn_sel_o, rsp_data_o, rsp_err_o);
        else begin
          bad++;
          $display("FAIL %s cyc=%0d gnt=%b rsp=%b sel=%b data=%0h err=%b | want cyc=%0d vec=%b sel=%b data=%0h err=%b",
                   e.is_rsp ? "rsp" : "gnt", cyc, gnt_o, rsp_valid_o, adc_chn_sel_o, rsp_data_o,
                   rsp_err_o, e.at, e.vec, e.sel, e.data, e.err);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
    $fatal(1, "watchdog expired");
  end

  logic [DW-1:0] tdat [4];
  int c, r, t, a, b, ai, p, a2, x;

  initial begin
    tdat[0] = 10'h101; tdat[1] = 10'h202; tdat[2] = 10'h0AA; tdat[3] = 10'h155;
    rst = 1'b1; req = 2'b00; req_chn = 2'b00; adc_d = '0; adc_d_val = 1'b0;
    cfg_pwrup_time = 4'd3; cfg_timeout = 8'd0;
    repeat (3) tick();
    chk("rst_pd",    32'(adc_pd_o), 32'd1);
    chk("rst_sel",   32'(adc_chn_sel_o), 32'd0);
    chk("rst_gnt",   32'(gnt_o), 32'd0);
    chk("rst_rsp",   32'(rsp_valid_o), 32'd0);
    chk("rst_data",  32'(rsp_data_o), 32'd0);
    chk("rst_err",   32'(rsp_err_o), 32'd0);
    mon_en = 1'b1;
    rst = 1'b0;
    tick();

    // Cold start: requester 0 on channel 1, data in the second CONV cycle.
    c = cyc;
    chk("cold_pd_c0", 32'(adc_pd_o), 32'd1);
    req = 2'b01; req_chn = 2'b01;
    push(0, c + 6, 2'b01, 2'b10, '0, 1'b0);
    push(1, c + 8, 2'b01, 2'b00, 10'h007, 1'b0);
    tick();
    chk("cold_pd_c1", 32'(adc_pd_o), 32'd0);
    wait_to(c + 6); req = 2'b00;
    wait_to(c + 7); adc_d = 10'h007; adc_d_val = 1'b1;
    wait_to(c + 8); adc_d_val = 1'b0;

    // Tie held for four back-to-back conversions; data in the first CONV cycle each time.
    r = cyc;
    req = 2'b11; req_chn = 2'b10;
    for (int k = 0; k < 4; k++) begin
      push(0, r + 1 + 2*k, (k % 2 == 0) ? 2'b01 : 2'b10, (k % 2 == 0) ? 2'b01 : 2'b10, '0, 1'b0);
      push(1, r + 2 + 2*k, (k % 2 == 0) ? 2'b01 : 2'b10, 2'b00, tdat[k], 1'b0);
    end
    for (int k = 0; k < 4; k++) begin
      wait_to(r + 1 + 2*k); adc_d = tdat[k]; adc_d_val = 1'b1;
      wait_to(r + 2 + 2*k); adc_d_val = 1'b0;
    end

    // Timeout of 5 cycles on requester 1, channel 0.
    t = cyc;
    cfg_timeout = 8'd5; req = 2'b10; req_chn = 2'b00;
    push(0, t + 1, 2'b10, 2'b01, '0, 1'b0);
    push(1, t + 6, 2'b10, 2'b00, '0, 1'b1);
    wait_to(t + 1); req = 2'b00;
    wait_to(t + 6);

    // Timeout disabled: data arrives 300 cycles after grant.
    a = cyc;
    cfg_timeout = 8'd0; req = 2'b01; req_chn = 2'b00;
    push(0, a + 1, 2'b01, 2'b01, '0, 1'b0);
    push(1, a + 302, 2'b01, 2'b00, 10'h2C3, 1'b0);
    wait_to(a + 1); req = 2'b00;
    wait_to(a + 301); adc_d = 10'h2C3; adc_d_val = 1'b1;
    wait_to(a + 302); adc_d_val = 1'b0;

    // Data and timeout in the same (4th) CONV cycle: data wins.
    b = cyc;
    cfg_timeout = 8'd4; req = 2'b01; req_chn = 2'b01;
    push(0, b + 1, 2'b01, 2'b10, '0, 1'b0);
    push(1, b + 5, 2'b01, 2'b00, 10'h3FF, 1'b0);
    wait_to(b + 1); req = 2'b00;
    wait_to(b + 4); adc_d = 10'h3FF; adc_d_val = 1'b1;
    wait_to(b + 5); adc_d_val = 1'b0;

    // Idle power-down: 16 request-free ARB cycles, pd rises on the 17th.
    ai = cyc;
    wait_to(ai + 15); chk("idle_pd_16th", 32'(adc_pd_o), 32'd0);
    wait_to(ai + 16); chk("idle_pd_17th", 32'(adc_pd_o), 32'd1);

    // Wake up again, then request in the 16th idle cycle: grant wins.
    p = cyc;
    req = 2'b10; req_chn = 2'b10;
    push(0, p + 6, 2'b10, 2'b10, '0, 1'b0);
    push(1, p + 7, 2'b10, 2'b00, 10'h0F0, 1'b0);
    wait_to(p + 6); req = 2'b00; adc_d = 10'h0F0; adc_d_val = 1'b1;
    wait_to(p + 7); adc_d_val = 1'b0;
    a2 = cyc;
    wait_to(a2 + 15); req = 2'b01; req_chn = 2'b00;
    push(0, a2 + 16, 2'b01, 2'b01, '0, 1'b0);
    wait_to(a2 + 16); req = 2'b00;
    chk("race_pd", 32'(adc_pd_o), 32'd0);

    // Reset in CONV: conversion abandoned silently.
    wait_to(a2 + 17); rst = 1'b1;
    wait_to(a2 + 18);
    chk("mid_rst_pd",  32'(adc_pd_o), 32'd1);
    chk("mid_rst_sel", 32'(adc_chn_sel_o), 32'd0);
    chk("mid_rst_rsp", 32'(rsp_valid_o), 32'd0);
    wait_to(a2 + 19); rst = 1'b0;

    // Tie after reset: requester 0 first, then requester 1 alone.
    x = cyc;
    req = 2'b11; req_chn = 2'b11;
    push(0, x + 6, 2'b01, 2'b10, '0, 1'b0);
    push(1, x + 7, 2'b01, 2'b00, 10'h123, 1'b0);
    push(0, x + 8, 2'b10, 2'b10, '0, 1'b0);
    push(1, x + 9, 2'b10, 2'b00, 10'h321, 1'b0);
    wait_to(x + 6); req = 2'b10; adc_d = 10'h123; adc_d_val = 1'b1;
    wait_to(x + 7); adc_d_val = 1'b0;
    wait_to(x + 8); req = 2'b00; adc_d = 10'h321; adc_d_val = 1'b1;
    wait_to(x + 9); adc_d_val = 1'b0;
    repeat (5) tick();

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
